// File: rtl/ro_puf_pkg.sv
// Shared types and default constants for the RO-PUF measurement stage.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        COMPARE = 2'd3
    } state_t;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WINDOW_CYCLES = 1024;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Larger of two integers, used to size the shared cycle timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one ring-oscillator output, detects its rising edges and
// counts them in a saturating counter while count_en is high.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic             rise_s;
    logic [CNT_W-1:0] count_r;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= ro_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Rising edge seen on the synchronised oscillator signal.
    always_comb begin
        rise_s = sync2_r & ~sync3_r;
    end

    // Saturating edge counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (count_en && rise_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ro_pair_comparator.sv
// Enables an oscillator pair, counts each one's edges over a fixed window
// after a settling period, and registers which one was faster.
module ro_pair_comparator
    import ro_puf_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int TMR_W = $clog2(max_int(WINDOW_CYCLES, SETTLE_CYCLES) + 1);

    localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE     = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    state_t           state_r;
    logic [TMR_W-1:0] timer_r;
    logic             ro_en_r;
    logic             busy_r;
    logic             done_r;
    logic             response_r;
    logic             tie_r;
    logic [CNT_W-1:0] count_a_r;
    logic [CNT_W-1:0] count_b_r;

    logic             clear_s;
    logic             count_en_s;
    logic [CNT_W-1:0] work_a_s;
    logic [CNT_W-1:0] work_b_s;

    // Working counters clear on the accepted start and only count in MEASURE.
    always_comb begin
        clear_s    = (state_r == IDLE) && start;
        count_en_s = (state_r == MEASURE);
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_in    (ro_a),
        .clear    (clear_s),
        .count_en (count_en_s),
        .count    (work_a_s)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_in    (ro_b),
        .clear    (clear_s),
        .count_en (count_en_s),
        .count    (work_b_s)
    );

    // Measurement sequencer with cycle timer and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            timer_r    <= TMR_ZERO;
            ro_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            response_r <= 1'b0;
            tie_r      <= 1'b0;
            count_a_r  <= CNT_ZERO;
            count_b_r  <= CNT_ZERO;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= SETTLE;
                        timer_r <= TMR_ZERO;
                        ro_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        ro_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (timer_r == SETTLE_LAST) begin
                        state_r <= MEASURE;
                        timer_r <= TMR_ZERO;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                MEASURE: begin
                    if (timer_r == WINDOW_LAST) begin
                        state_r <= COMPARE;
                        timer_r <= TMR_ZERO;
                        ro_en_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                COMPARE: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    count_a_r  <= work_a_s;
                    count_b_r  <= work_b_s;
                    response_r <= (work_a_s > work_b_s);
                    tie_r      <= (work_a_s == work_b_s);
                end
                default: begin
                    state_r <= IDLE;
                    timer_r <= TMR_ZERO;
                    ro_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ro_en    = ro_en_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign response = response_r;
    assign tie      = tie_r;
    assign count_a  = count_a_r;
    assign count_b  = count_b_r;

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Directed self-checking bench for ro_pair_comparator: timing, comparison,
// tie, saturation, start handshake and asynchronous reset.
module tb_ro_pair_comparator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_sat;
    logic        ro_a;
    logic        ro_b_free;
    logic        ro_b;
    logic        follow;
    int          half_a;
    int          half_b;

    logic        m_ro_en, m_busy, m_done, m_response, m_tie;
    logic [15:0] m_count_a, m_count_b;
    logic        s_ro_en, s_busy, s_done, s_response, s_tie;
    logic [3:0]  s_count_a, s_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    assign ro_b = follow ? ro_a : ro_b_free;

    ro_pair_comparator #(.CNT_W(16), .WINDOW_CYCLES(120), .SETTLE_CYCLES(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ro_a     (ro_a),
        .ro_b     (ro_b),
        .ro_en    (m_ro_en),
        .busy     (m_busy),
        .done     (m_done),
        .response (m_response),
        .tie      (m_tie),
        .count_a  (m_count_a),
        .count_b  (m_count_b)
    );

    ro_pair_comparator #(.CNT_W(4), .WINDOW_CYCLES(100), .SETTLE_CYCLES(4)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_sat),
        .ro_a     (ro_a),
        .ro_b     (ro_a),
        .ro_en    (s_ro_en),
        .busy     (s_busy),
        .done     (s_done),
        .response (s_response),
        .tie      (s_tie),
        .count_a  (s_count_a),
        .count_b  (s_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator A; toggle times stay clear of clk edges.
    initial begin
        ro_a = 1'b0;
        #2;
        forever begin
            #(half_a) ro_a = ~ro_a;
        end
    end

    // Free-running oscillator B.
    initial begin
        ro_b_free = 1'b0;
        #2;
        forever begin
            #(half_b) ro_b_free = ~ro_b_free;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol = 0);
        longint diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // One run on the main instance; start sampled at edge 0, optional extra
    // start pulse sampled at edge pulse_at.
    task automatic run_main(input int pulse_at, output int done_cyc,
                            output int en_cyc, output int busy_cyc, output int ndone);
        done_cyc = -1;
        en_cyc   = 0;
        busy_cyc = 0;
        ndone    = 0;
        for (int k = 0; k <= 200; k++) begin
            @(negedge clk);
            start = (k == 0) || (k == pulse_at);
            @(posedge clk);
            #1;
            if (m_ro_en) en_cyc++;
            if (m_busy) busy_cyc++;
            if (m_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    int done_cyc, en_cyc, busy_cyc, ndone;
    int done_times[4];
    int sat_done;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start_sat = 1'b0;
        follow    = 1'b0;
        half_a    = 20;
        half_b    = 30;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ro_en",    m_ro_en, 0);
        check("rst_busy",     m_busy, 0);
        check("rst_done",     m_done, 0);
        check("rst_response", m_response, 0);
        check("rst_tie",      m_tie, 0);
        check("rst_count_a",  m_count_a, 0);
        check("rst_count_b",  m_count_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ro_en", m_ro_en, 0);

        // Basic: A at 40 ns, B at 60 ns.
        run_main(-1, done_cyc, en_cyc, busy_cyc, ndone);
        check("basic_done_cyc", done_cyc, 125);
        check("basic_ndone",    ndone, 1);
        check("basic_en_cyc",   en_cyc, 124);
        check("basic_busy_cyc", busy_cyc, 125);
        check("basic_count_a",  m_count_a, 30, 1);
        check("basic_count_b",  m_count_b, 20, 1);
        check("basic_response", m_response, 1);
        check("basic_tie",      m_tie, 0);
        check("idle_after_en",  m_ro_en, 0);

        // Reverse: A at 60 ns, B at 40 ns.
        half_a = 30;
        half_b = 20;
        repeat (10) @(posedge clk);
        run_main(-1, done_cyc, en_cyc, busy_cyc, ndone);
        check("rev_count_a",  m_count_a, 20, 1);
        check("rev_count_b",  m_count_b, 30, 1);
        check("rev_response", m_response, 0);
        check("rev_tie",      m_tie, 0);

        // Tie: identical 50 ns waveform on both inputs.
        half_a = 25;
        follow = 1'b1;
        repeat (10) @(posedge clk);
        run_main(-1, done_cyc, en_cyc, busy_cyc, ndone);
        check("tie_count_a",  m_count_a, 24, 1);
        check("tie_count_b",  m_count_b, 24, 1);
        check("tie_tie",      m_tie, 1);
        check("tie_response", m_response, 0);

        // Start pulsed during MEASURE is ignored.
        half_a = 20;
        half_b = 30;
        follow = 1'b0;
        repeat (10) @(posedge clk);
        run_main(60, done_cyc, en_cyc, busy_cyc, ndone);
        check("midstart_done_cyc", done_cyc, 125);
        check("midstart_ndone",    ndone, 1);
        check("midstart_en_cyc",   en_cyc, 124);

        // Start held high: new run every 126 cycles, one done each.
        ndone = 0;
        for (int k = 0; k <= 420; k++) begin
            @(negedge clk);
            start = (k <= 252);
            @(posedge clk);
            #1;
            if (m_done) begin
                if (ndone < 4) done_times[ndone] = k;
                ndone++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held_ndone", ndone, 3);
        check("held_done0", done_times[0], 125);
        check("held_done1", done_times[1], 251);
        check("held_done2", done_times[2], 377);

        // Reverse run so results are non-zero before the reset test.
        half_a = 30;
        half_b = 20;
        repeat (10) @(posedge clk);
        run_main(-1, done_cyc, en_cyc, busy_cyc, ndone);
        check("pre_rst_count_b", m_count_b, 30, 1);

        // Reset asserted mid-MEASURE at cycle 60.
        half_a = 20;
        half_b = 30;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("pre_rst_busy", m_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ro_en",    m_ro_en, 0);
        check("mrst_busy",     m_busy, 0);
        check("mrst_done",     m_done, 0);
        check("mrst_count_a",  m_count_a, 0);
        check("mrst_count_b",  m_count_b, 0);
        check("mrst_response", m_response, 0);
        check("mrst_tie",      m_tie, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_main(-1, done_cyc, en_cyc, busy_cyc, ndone);
        check("post_rst_done_cyc", done_cyc, 125);
        check("post_rst_count_a",  m_count_a, 30, 1);
        check("post_rst_count_b",  m_count_b, 20, 1);
        check("post_rst_response", m_response, 1);

        // Saturation: 4-bit counters, 100-cycle window, 30 ns oscillators.
        half_a = 15;
        repeat (10) @(posedge clk);
        sat_done = -1;
        for (int k = 0; k <= 150; k++) begin
            @(negedge clk);
            start_sat = (k == 0);
            @(posedge clk);
            #1;
            if (s_done && sat_done < 0) sat_done = k;
        end
        @(negedge clk);
        start_sat = 1'b0;
        check("sat_done_cyc", sat_done, 105);
        check("sat_count_a",  s_count_a, 15);
        check("sat_count_b",  s_count_b, 15);
        check("sat_tie",      s_tie, 1);
        check("sat_response", s_response, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
